// File: rtl/stream_muxn_if.sv
// Handshake bundle for stream_muxn: N valid/ready input channels, one registered output stream.
interface stream_muxn_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned SEL_W  = $clog2(NUM_IN)
) ();
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [SEL_W-1:0]        out_src;

   // Producer/consumer side that drives the mux
   modport master (
      output mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_src
   );

   // Mux side
   modport slave (
      input  mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_src
   );
endinterface

// File: rtl/stream_muxn.sv
// N:1 valid/ready stream mux with fixed-select or round-robin arbitration and one registered output stage.
// Optional STREAM_MUXN_STATS_EN adds a saturating accepted-transfer counter on port xfer_count.
module stream_muxn #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
   input  logic         clk,
   input  logic         rst,
   stream_muxn_if.slave bus
`ifdef STREAM_MUXN_STATS_EN
   ,
   output logic [15:0]  xfer_count
`endif
);

   logic [NUM_IN-1:0] grant_c;
   logic              found_c;
   logic              load_c;
   logic              xfer_c;
   logic [WIDTH-1:0]  win_data_c;
   logic [SEL_W-1:0]  win_src_c;

   logic              out_valid_q,  out_valid_d;
   logic [WIDTH-1:0]  out_data_q,   out_data_d;
   logic [SEL_W-1:0]  out_src_q,    out_src_d;
   logic [SEL_W-1:0]  last_grant_q, last_grant_d;

   // Grant: fixed index in mode 0, rotating priority starting after last_grant in mode 1
   always_comb begin
      grant_c = '0;
      found_c = 1'b0;
      if (bus.mode) begin
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!found_c && bus.in_valid[i] && (i > 32'(last_grant_q))) begin
               grant_c[i] = 1'b1;
               found_c    = 1'b1;
            end
         end
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!found_c && bus.in_valid[i] && (i <= 32'(last_grant_q))) begin
               grant_c[i] = 1'b1;
               found_c    = 1'b1;
            end
         end
      end else begin
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (32'(bus.sel) == i) grant_c[i] = bus.in_valid[i];
         end
      end
   end

   // One-hot grant to winner data/index
   always_comb begin
      win_data_c = '0;
      win_src_c  = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (grant_c[i]) begin
            win_data_c = bus.in_data[i*WIDTH +: WIDTH];
            win_src_c  = SEL_W'(i);
         end
      end
   end

   assign load_c       = ~out_valid_q | bus.out_ready;
   assign xfer_c       = load_c & (|grant_c) & ~rst;
   assign bus.in_ready = (load_c & ~rst) ? grant_c : '0;

   // Output stage next state; the pointer only advances on round-robin transfers
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_src_d    = out_src_q;
      last_grant_d = last_grant_q;
      if (load_c) out_valid_d = |grant_c;
      if (xfer_c) begin
         out_data_d = win_data_c;
         out_src_d  = win_src_c;
         if (bus.mode) last_grant_d = win_src_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_src_q    <= '0;
         last_grant_q <= SEL_W'(NUM_IN - 1);
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_src_q    <= out_src_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_src   = out_src_q;

`ifdef STREAM_MUXN_STATS_EN
   logic [15:0] xfer_count_q, xfer_count_d;

   // Accepted output beats, saturating
   always_comb begin
      xfer_count_d = xfer_count_q;
      if (out_valid_q && bus.out_ready && (xfer_count_q != 16'hFFFF))
         xfer_count_d = xfer_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) xfer_count_q <= '0;
      else     xfer_count_q <= xfer_count_d;
   end

   assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_stream_muxn.sv
// Directed bench for stream_muxn: scoreboard on the 4-channel instance, direct checks on a 3-channel one.
module tb_stream_muxn;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   stream_muxn_if #(.WIDTH(W), .NUM_IN(4)) b4 ();
   stream_muxn_if #(.WIDTH(W), .NUM_IN(3)) b3 ();

`ifdef STREAM_MUXN_STATS_EN
   logic [15:0] cnt4, cnt3;
`endif

   stream_muxn #(.WIDTH(W), .NUM_IN(4)) u4 (
      .clk(clk), .rst(rst), .bus(b4)
`ifdef STREAM_MUXN_STATS_EN
      , .xfer_count(cnt4)
`endif
   );

   stream_muxn #(.WIDTH(W), .NUM_IN(3)) u3 (
      .clk(clk), .rst(rst), .bus(b3)
`ifdef STREAM_MUXN_STATS_EN
      , .xfer_count(cnt3)
`endif
   );

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  src;
   } beat_t;

   beat_t      sb_q[$];
   beat_t      last_exp;
   int         errors = 0;
   int         checks = 0;
   logic [7:0] tag    = 8'd0;
   bit         sb_off = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Channel word carries a per-cycle tag so duplicated or stale beats are visible
   function automatic logic [31:0] dat(input int i);
      return {16'h0, tag, 8'(8'hA0 + i)};
   endfunction

   task automatic apply_data();
      for (int i = 0; i < 4; i++) b4.in_data[i*32 +: 32] = dat(i);
   endtask

   // Called at posedge+1 with inputs applied; checks ready at negedge, records expected beats
   task automatic cyc(input string nm, input logic [3:0] exp_rdy, input int exp_ov);
      @(negedge clk);
      chk({nm, "_rdy"}, 32'(b4.in_ready), 32'(exp_rdy));
      if (exp_ov >= 0) chk({nm, "_ov"}, 32'(b4.out_valid), 32'(exp_ov));
      for (int i = 0; i < 4; i++) begin
         if (exp_rdy[i] && !sb_off) begin
            last_exp = '{data: dat(i), src: 2'(i)};
            sb_q.push_back(last_exp);
         end
      end
      @(posedge clk);
      #1;
      tag++;
      apply_data();
   endtask

   // Monitor: every accepted output beat must match the oldest expected beat
   always @(negedge clk) begin
      beat_t e;
      if (!rst && !sb_off && b4.out_valid && b4.out_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: got src=%0d data=%0h expected no beat", b4.out_src, b4.out_data);
         end else begin
            e = sb_q.pop_front();
            if (b4.out_data !== e.data || b4.out_src !== e.src) begin
               errors++;
               $display("FAIL sb_beat: got src=%0d data=%0h expected src=%0d data=%0h",
                        b4.out_src, b4.out_data, e.src, e.data);
            end
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      b4.mode = 1'b1; b4.sel = 2'd0; b4.in_valid = 4'hF; b4.out_ready = 1'b1;
      apply_data();
      b3.mode = 1'b0; b3.sel = 2'd0; b3.in_valid = 3'b000; b3.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) b3.in_data[i*32 +: 32] = 32'hB0 + 32'(i);

      // Reset with all channels requesting
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rdy",  32'(b4.in_ready),  32'h0);
      chk("rst_ov",   32'(b4.out_valid), 32'h0);
      chk("rst_src",  32'(b4.out_src),   32'h0);
      chk("rst_data", b4.out_data,       32'h0);
      @(posedge clk); #1 rst = 1'b0;

      // Round-robin fairness, full throughput
      cyc("rr0", 4'b0001, 0);
      cyc("rr1", 4'b0010, 1);
      cyc("rr2", 4'b0100, 1);
      cyc("rr3", 4'b1000, 1);
      cyc("rr4", 4'b0001, 1);
      cyc("rr5", 4'b0010, 1);

      // Fixed select, invalid selected channel, then RR pointer untouched by fixed mode
      b4.mode = 1'b0; b4.sel = 2'd2;
      cyc("fx2", 4'b0100, 1);
      b4.sel = 2'd3;
      cyc("fx3", 4'b1000, 1);
      b4.sel = 2'd1; b4.in_valid = 4'b1101;
      cyc("fx_inv", 4'b0000, 1);
      b4.mode = 1'b1; b4.in_valid = 4'hF;
      cyc("rr_after_fx", 4'b0100, 0);

      // Backpressure holds the word; release consumes and reloads on one edge
      b4.out_ready = 1'b0;
      repeat (3) begin
         cyc("bp", 4'b0000, 1);
         chk("bp_data", b4.out_data,       last_exp.data);
         chk("bp_src",  32'(b4.out_src),   32'(last_exp.src));
      end
      b4.out_ready = 1'b1;
      cyc("bp_rel", 4'b1000, 1);

      // Idle cycle must not move the pointer
      b4.in_valid = 4'b0000;
      cyc("idle", 4'b0000, 1);
      b4.in_valid = 4'hF;
      cyc("idle_ptr", 4'b0001, 0);

      // Reset while a word is held: word dropped, pointer back to channel-0 priority
      b4.in_valid = 4'b0010;
      cyc("rr_ch1", 4'b0010, 1);
      b4.out_ready = 1'b0; b4.in_valid = 4'hF;
      #2 rst = 1'b1;
      sb_q.delete();
      @(negedge clk);
      chk("mid_rst_rdy", 32'(b4.in_ready),  32'h0);
      chk("mid_rst_ov",  32'(b4.out_valid), 32'h0);
      chk("mid_rst_src", 32'(b4.out_src),   32'h0);
      @(posedge clk); #1 rst = 1'b0;
      b4.out_ready = 1'b1; b4.in_valid = 4'b1010;
      cyc("rst_ptr", 4'b0010, 0);
      b4.in_valid = 4'b0000;
      cyc("drain", 4'b0000, 1);
      cyc("drain2", 4'b0000, 0);
      chk("sb_empty", 32'(sb_q.size()), 32'h0);

      // 3-channel instance: out-of-range sel, then wrap-around to ch2 twice
      b3.mode = 1'b0; b3.sel = 2'd0; b3.in_valid = 3'b111;
      @(negedge clk);
      chk("n3_fx0_rdy", 32'(b3.in_ready), 32'b001);
      @(posedge clk); #1 b3.sel = 2'd3;
      @(negedge clk);
      chk("n3_sel3_rdy", 32'(b3.in_ready),  32'b000);
      chk("n3_ov1",      32'(b3.out_valid), 32'h1);
      chk("n3_data0",    b3.out_data,       32'hB0);
      @(posedge clk); #1 b3.mode = 1'b1; b3.in_valid = 3'b100;
      @(negedge clk);
      chk("n3_drop",   32'(b3.out_valid), 32'h0);
      chk("n3_rr_rdy", 32'(b3.in_ready),  32'b100);
      @(posedge clk); #1;
      @(negedge clk);
      chk("n3_wrap_rdy", 32'(b3.in_ready),  32'b100);
      chk("n3_src",      32'(b3.out_src),   32'h2);
      chk("n3_ov2",      32'(b3.out_valid), 32'h1);
      @(posedge clk); #1 b3.in_valid = 3'b000;
      @(negedge clk);
      chk("n3_src2",  32'(b3.out_src), 32'h2);
      chk("n3_data2", b3.out_data,     32'hB2);
      @(posedge clk); #1;

`ifdef STREAM_MUXN_STATS_EN
      // Accepted-beat counter: 10 beats, saturation, reset
      b4.in_valid = 4'b0000; rst = 1'b1; sb_q.delete();
      @(negedge clk);
      chk("cnt_rst", 32'(cnt4), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      b4.mode = 1'b1; b4.in_valid = 4'hF; b4.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) cyc("cnt_beat", 4'b0001 << (k % 4), -1);
      b4.in_valid = 4'b0000;
      cyc("cnt_drain", 4'b0000, 1);
      chk("cnt10", 32'(cnt4), 32'd10);
      sb_off = 1'b1; b4.in_valid = 4'hF;
      repeat (70000) @(posedge clk);
      #1 chk("cnt_sat", 32'(cnt4), 32'hFFFF);
      rst = 1'b1;
      #2 chk("cnt_rst2", 32'(cnt4), 32'h0);
      @(posedge clk); #1 rst = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
